// File: rtl/apb4_cmd_master_pkg.sv
// apb4_cmd_master shared types.
// State encoding, command/response bundles.
package apb4_cmd_master_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic [2:0]        prot;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              tmo;
  } rsp_t;

  function automatic int cnt_w(int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/apb4_cmd_master_if.sv
// Command/response stream plus APB4 bus.
// master = initiator side, slave = environment.
interface apb4_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic          cmd_write_i;
  logic [DW-1:0] cmd_wdata_i;
  logic [3:0]    cmd_wstrb_i;
  logic [2:0]    cmd_prot_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_tmo_o;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_write_i,
    input  cmd_wdata_i, cmd_wstrb_i, cmd_prot_i,
    input  rsp_ready_i, prdata, pready, pslverr,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o,
    output rsp_err_o, rsp_tmo_o,
    output paddr, pprot, psel, penable,
    output pwrite, pwdata, pstrb
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_write_i,
    output cmd_wdata_i, cmd_wstrb_i, cmd_prot_i,
    output rsp_ready_i, prdata, pready, pslverr,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o, rsp_tmo_o,
    input  paddr, pprot, psel, penable,
    input  pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb4_cmd_master_rspbuf.sv
// One-entry valid/ready holding register for rsp_t.
// Push and pop in the same cycle refill without a bubble.
module apb4_cmd_master_rspbuf
  import apb4_cmd_master_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rsp_t rsp_i,
  input  logic ready_i,
  output logic valid_o,
  output rsp_t rsp_o
);
  logic vld_d;
  logic vld_q;

  assign vld_d = push_i | (vld_q & ~ready_i);

  dffr #(.W(1)) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vld_d),
    .q     (vld_q)
  );

  dffer #(.W($bits(rsp_t))) u_dat (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push_i),
    .d     (rsp_i),
    .q     (rsp_o)
  );

  assign valid_o = vld_q;
endmodule

// File: rtl/dffr.sv
// Shared flop primitives, async active-low reset to 0.
// dffr: plain register; dffer: register with load enable.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Plain resettable register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule

module dffer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Resettable register, loads only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/apb4_cmd_master.sv
// APB4 initiator: valid/ready commands to APB transfers.
// One transfer in flight, one buffered response.
module apb4_cmd_master
  import apb4_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               hclk,
  input logic               hresetn,
  apb4_cmd_master_if.master bus
);
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_e          st_q;
  state_e          st_d;
  cmd_t            cmd_d;
  cmd_t            cmd_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_q;
  logic            rdy_q;
  logic            idle;
  logic            setup;
  logic            access;
  logic            hs;
  logic            done;
  logic            tmo_hit;
  logic            push;
  logic            rbv;
  rsp_t            rsp_d;
  rsp_t            rsp_q;

  assign idle   = (st_q == IDLE);
  assign setup  = (st_q == SETUP);
  assign access = (st_q == ACCESS);

  assign done    = access & bus.pready;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) & access
                 & ~bus.pready & (cnt_q == TMO);
  assign push    = done | tmo_hit;

  // rdy_q keeps cmd_ready_o low while reset is held
  assign bus.cmd_ready_o = rdy_q & (
      (idle & (~rbv | bus.rsp_ready_i))
    | (done & bus.rsp_ready_i));
  assign hs = bus.cmd_valid_i & bus.cmd_ready_o;

  dffr #(.W(1)) u_rdy (
    .clk   (hclk),
    .rst_n (hresetn),
    .d     (1'b1),
    .q     (rdy_q)
  );

  // Command capture; strobes are meaningless on reads
  always_comb begin
    cmd_d.addr  = bus.cmd_addr_i[ADDR_WIDTH-1:0];
    cmd_d.write = bus.cmd_write_i;
    cmd_d.wdata = bus.cmd_wdata_i[DATA_WIDTH-1:0];
    cmd_d.wstrb = bus.cmd_write_i ? bus.cmd_wstrb_i
                                  : 4'h0;
    cmd_d.prot  = bus.cmd_prot_i;
  end

  dffer #(.W($bits(cmd_t))) u_cmd (
    .clk   (hclk),
    .rst_n (hresetn),
    .en    (hs),
    .d     (cmd_d),
    .q     (cmd_q)
  );

  // Wait-state counter: cleared in SETUP
  always_comb begin
    cnt_d = cnt_q;
    if (setup)
      cnt_d = '0;
    else if (access & ~bus.pready)
      cnt_d = cnt_q + 1'b1;
  end

  dffr #(.W(CW)) u_cnt (
    .clk   (hclk),
    .rst_n (hresetn),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  // FSM state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) st_q <= IDLE;
    else          st_q <= st_d;
  end

  // FSM next state; completion beats timeout
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:   if (hs) st_d = SETUP;
      SETUP:  st_d = ACCESS;
      ACCESS: begin
        if (done)         st_d = hs ? SETUP : IDLE;
        else if (tmo_hit) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Response word; rdata only for clean reads
  always_comb begin
    rsp_d.rdata = (done & ~cmd_q.write & ~bus.pslverr)
                ? bus.prdata : '0;
    rsp_d.err   = done ? bus.pslverr : 1'b1;
    rsp_d.tmo   = ~done;
  end

  apb4_cmd_master_rspbuf u_rspbuf (
    .clk     (hclk),
    .rst_n   (hresetn),
    .push_i  (push),
    .rsp_i   (rsp_d),
    .ready_i (bus.rsp_ready_i),
    .valid_o (rbv),
    .rsp_o   (rsp_q)
  );

  assign bus.paddr   = cmd_q.addr;
  assign bus.pwrite  = cmd_q.write;
  assign bus.pwdata  = cmd_q.wdata;
  assign bus.pstrb   = cmd_q.wstrb;
  assign bus.pprot   = cmd_q.prot;
  assign bus.psel    = ~idle;
  assign bus.penable = access;

  assign bus.rsp_valid_o = rbv;
  assign bus.rsp_rdata_o = rsp_q.rdata;
  assign bus.rsp_err_o   = rsp_q.err;
  assign bus.rsp_tmo_o   = rsp_q.tmo;
endmodule

// File: tb/tb_apb4_cmd_master.sv
// Bench for apb4_cmd_master: directed steps then random traffic.
// Responses and APB beats are checked against a reference model.
module tb_apb4_cmd_master;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int idle_cnt = 0;

  apb4_cmd_master_if #(.AW(32), .DW(32)) bus ();

  apb4_cmd_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .hclk    (clk),
    .hresetn (rst_n),
    .bus     (bus.master)
  );

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } scfg_t;

  scfg_t       cfg_q[$];
  logic [71:0] apb_q[$];
  logic [33:0] rsp_q[$];

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] model(logic w, int waits,
                                        logic [31:0] rd,
                                        logic er);
    if (waits > TMO) return {32'h0, 1'b1, 1'b1};
    if (w)           return {32'h0, er, 1'b0};
    if (er)          return {32'h0, 1'b1, 1'b0};
    return {rd, 2'b00};
  endfunction

  function automatic logic [109:0] all_out();
    return {bus.cmd_ready_o, bus.rsp_valid_o,
            bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_tmo_o,
            bus.psel, bus.penable, bus.pwrite, bus.paddr,
            bus.pwdata, bus.pstrb, bus.pprot};
  endfunction

  // APB slave: configured wait states, junk when ignored
  scfg_t cur;
  int    wcnt;
  always @(posedge clk) begin
    #1;
    if (bus.psel && !bus.penable) begin
      if (cfg_q.size() != 0) cur = cfg_q.pop_front();
      else cur = '{0, 32'h0, 1'b0};
      wcnt        = 0;
      bus.pready  = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom_range(0, 1));
    end else if (bus.psel && bus.penable) begin
      if (wcnt >= cur.waits) begin
        bus.pready  = 1'b1;
        bus.prdata  = cur.rdata;
        bus.pslverr = cur.err;
      end else begin
        bus.pready  = 1'b0;
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom_range(0, 1));
      end
      wcnt++;
    end else begin
      bus.pready  = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: APB beats and response stream
  logic [71:0] seen;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.psel && !bus.penable) begin
        seen = {bus.paddr, bus.pwrite, bus.pwdata,
                bus.pstrb, bus.pprot};
        if (apb_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL apb_unexp obs=%0h exp=none", seen);
        end else chk("apb_setup", seen, apb_q.pop_front());
      end
      if (bus.psel && bus.penable)
        chk("apb_stable", {bus.paddr, bus.pwrite, bus.pwdata,
                           bus.pstrb, bus.pprot}, seen);
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL rsp_unexp obs=%0h exp=none",
                 bus.rsp_rdata_o);
        end else
          chk("rsp", {bus.rsp_rdata_o, bus.rsp_err_o,
                      bus.rsp_tmo_o}, rsp_q.pop_front());
      end
      if (!bus.psel) idle_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] a, logic w,
                      logic [31:0] d, logic [3:0] s,
                      logic [2:0] p, int waits,
                      logic [31:0] rd, logic er);
    scfg_t c;
    c.waits = waits;
    c.rdata = rd;
    c.err   = er;
    cfg_q.push_back(c);
    apb_q.push_back({a, w, d, (w ? s : 4'h0), p});
    rsp_q.push_back(model(w, waits, rd, er));
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = a;
    bus.cmd_write_i = w;
    bus.cmd_wdata_i = d;
    bus.cmd_wstrb_i = s;
    bus.cmd_prot_i  = p;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) break;
      if (n == 200) begin
        total++;
        bad++;
        $error("FAIL cmd_accept obs=stalled exp=handshake");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid_o && n < 60);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && rsp_q.size() != 0; n++)
      tick();
    chk("drain", rsp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_wdata_i = '0;
    bus.cmd_wstrb_i = '0;
    bus.cmd_prot_i  = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_out(), 0);
    chk("reset_rdy", bus.cmd_ready_o, 0);
    rst_n = 1'b1;
    tick();
    tick();

    send(32'h8, 1'b0, 32'h0, 4'hF, 3'd0, 0, 32'h1234, 1'b0);
    @(negedge clk);
    chk("t1_setup", {bus.psel, bus.penable}, 2'b10);
    @(negedge clk);
    chk("t1_access", {bus.psel, bus.penable}, 2'b11);
    @(negedge clk);
    chk("t1_rsp", {bus.rsp_valid_o, bus.psel}, 2'b10);
    chk("t1_rdata", {bus.rsp_rdata_o, bus.rsp_err_o},
        {32'h1234, 1'b0});
    tick();

    send(32'hC, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'd2, 3,
         32'h0, 1'b0);
    wait_rsp(n);
    chk("t2_lat", n, 6);
    chk("t2_err", bus.rsp_err_o, 0);
    tick();

    send(32'h10, 1'b0, 32'h0, 4'h3, 3'd1, 1,
         32'hDEAD, 1'b1);
    wait_rsp(n);
    chk("t3_lat", n, 4);
    chk("t3_rsp", {bus.rsp_rdata_o, bus.rsp_err_o,
                   bus.rsp_tmo_o}, {32'h0, 2'b10});
    tick();

    send(32'h20, 1'b0, 32'h0, 4'h0, 3'd0, 1000,
         32'h77, 1'b0);
    wait_rsp(n);
    chk("t4_lat", n, 7);
    chk("t4_tmo", {bus.psel, bus.rsp_rdata_o, bus.rsp_err_o,
                   bus.rsp_tmo_o}, {1'b0, 32'h0, 2'b11});
    tick();
    send(32'h24, 1'b0, 32'h0, 4'h0, 3'd0, TMO,
         32'hBEEF, 1'b0);
    wait_rsp(n);
    chk("t4_edge_lat", n, 7);
    chk("t4_edge", {bus.rsp_rdata_o, bus.rsp_err_o,
                    bus.rsp_tmo_o}, {32'hBEEF, 2'b00});
    tick();

    send(32'h30, 1'b0, 32'h0, 4'h0, 3'd0, 0,
         32'h1111, 1'b0);
    idle_cnt = 0;
    send(32'h34, 1'b1, 32'h2222, 4'h5, 3'd3, 2,
         32'h0, 1'b0);
    @(negedge clk);
    chk("t5_b2b", {bus.psel, bus.penable}, 2'b10);
    chk("t5_idle", idle_cnt, 0);
    drain();

    bus.rsp_ready_i = 1'b0;
    send(32'h40, 1'b0, 32'h0, 4'h0, 3'd0, 0,
         32'h600D, 1'b0);
    fork
      send(32'h44, 1'b0, 32'h0, 4'h0, 3'd0, 0,
           32'h0B0B, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t6_acc_rdy", bus.cmd_ready_o, 0);
        repeat (4) begin
          @(negedge clk);
          chk("t6_block", {bus.cmd_ready_o, bus.rsp_valid_o,
                           bus.psel}, 3'b010);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
      end
    join
    drain();

    send(32'h50, 1'b0, 32'h0, 4'h0, 3'd0, 3,
         32'h5555, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", all_out(), 0);
    void'(rsp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_lost", bus.rsp_valid_o, 0);

    for (int i = 0; i < 40; i++) begin
      send($urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)),
           $urandom_range(0, 6), $urandom,
           ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 1)) tick();
    end
    drain();
    chk("apb_left", apb_q.size(), 0);
    chk("cfg_left", cfg_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
